// File: rtl/cmd_engine.sv
// cmd_engine: UART opcode parser, one-cycle command strobe and response serialiser with timeouts/NAK.
// Define CMD_ENGINE_CLI_EN for ASCII-hex terminal framing (':'/'>' prompts, hex payload/response, CR LF).
module cmd_engine #(
  parameter int P_DATA_BYTES  = 8,
  parameter int P_TIMEOUT_CYC = 1000000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_new,
  input  logic                      i_rx_err,
  input  logic                      i_tx_done,
  output logic                      o_tx_start,
  output logic [7:0]                o_tx_data,
  output logic [7:0]                o_cmd,
  output logic [8*P_DATA_BYTES-1:0] o_cmd_data,
  output logic                      o_cmd_new,
  input  logic                      i_resp_ready,
  input  logic [8*P_DATA_BYTES-1:0] i_resp_data,
  output logic                      o_loopback
);
  localparam int DW = 8*P_DATA_BYTES;
  localparam int CW = $clog2(2*P_DATA_BYTES+1);
  localparam int TW = $clog2(P_TIMEOUT_CYC+1);
`ifdef CMD_ENGINE_CLI_EN
  typedef enum logic [3:0] {IDLE, DECODE, PRE_D, RX, ISSUE, PRE_R, WAIT, TX, TXW, CR, LF, NAK} state_t;
  localparam state_t S_END = CR;
  localparam state_t S_RSP = PRE_R;
  localparam int K = 2;
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
           ((c | 8'h20) >= 8'h61 && (c | 8'h20) <= 8'h66) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
  endfunction
  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return {4'h0, n} + (n < 4'd10 ? 8'h30 : 8'h37);
  endfunction
`else
  typedef enum logic [3:0] {IDLE, DECODE, RX, ISSUE, WAIT, TX, TXW, NAK} state_t;
  localparam state_t S_END = IDLE;
  localparam state_t S_RSP = WAIT;
  localparam int K = 1;
`endif
  state_t state_q, state_d, ret_q, ret_d, send_ret;
  logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [7:0] cmd_q, cmd_d, tx_data_q, tx_data_d, tx_byte, send_byte;
  logic [DW-1:0] data_q, data_d, resp_q, resp_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic tx_start_q, tx_start_d, cmd_new_q, cmd_new_d, own_q, own_d;
  logic rx_new_q, rx_new_d, tx_done_q, tx_done_d;
  logic rx_edge, done_edge, tmo_hit, known, send;
  assign rx_edge   = i_rx_new & ~rx_new_q;
  assign done_edge = i_tx_done & ~tx_done_q;
  assign tmo_hit   = tmo_q == TW'(P_TIMEOUT_CYC - 1);
  assign known     = cmd_q == 8'h70 || cmd_q == 8'h72 || cmd_q == 8'h77;
  // out_cnt counts units still to send (bytes, or nibbles in CLI); index the captured response directly
`ifdef CMD_ENGINE_CLI_EN
  assign tx_byte = hex_enc(4'(resp_q >> {out_cnt_q - 1'b1, 2'b00}));
`else
  assign tx_byte = 8'(resp_q >> {out_cnt_q - 1'b1, 3'b000});
`endif
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    in_cnt_d = in_cnt_q;
    out_cnt_d = out_cnt_q;
    cmd_d = cmd_q;
    data_d = data_q;
    resp_d = resp_q;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;
    cmd_new_d = 1'b0;
    rx_new_d = i_rx_new;
    tx_done_d = i_tx_done;
    send = 1'b0;
    send_byte = 8'h15;
    send_ret = S_END;
    case (state_q)
      IDLE: if (rx_edge) begin
        cmd_d = i_rx_data;
        data_d = '0;
        state_d = DECODE;
      end
      DECODE: begin
        in_cnt_d = CW'(K * (cmd_q == 8'h70 ? 1 : cmd_q == 8'h77 ? P_DATA_BYTES : 0));
        out_cnt_d = CW'(K * (cmd_q == 8'h70 ? 1 : cmd_q == 8'h72 ? P_DATA_BYTES : 0));
`ifdef CMD_ENGINE_CLI_EN
        state_d = known ? PRE_D : NAK;
      end
      PRE_D: begin
        send = 1'b1;
        send_byte = 8'h3A;
        send_ret = in_cnt_q == '0 ? ISSUE : RX;
      end
      PRE_R: begin
        send = 1'b1;
        send_byte = 8'h3E;
        send_ret = WAIT;
      end
      CR: begin
        send = 1'b1;
        send_byte = 8'h0D;
        send_ret = LF;
      end
      LF: begin
        send = 1'b1;
        send_byte = 8'h0A;
        send_ret = IDLE;
      end
      RX: if (i_rx_err) state_d = NAK;
      else if (rx_edge) begin
        data_d = (data_q << 4) | DW'(hex_dec(i_rx_data)[3:0]);
        in_cnt_d = in_cnt_q - 1'b1;
        state_d = !hex_dec(i_rx_data)[4] ? NAK : in_cnt_q == CW'(1) ? ISSUE : RX;
      end else if (tmo_hit) state_d = NAK;
`else
        state_d = !known ? NAK : cmd_q == 8'h72 ? ISSUE : RX;
      end
      RX: if (i_rx_err) state_d = NAK;
      else if (rx_edge) begin
        data_d = (data_q << 8) | DW'(i_rx_data);
        in_cnt_d = in_cnt_q - 1'b1;
        state_d = in_cnt_q == CW'(1) ? ISSUE : RX;
      end else if (tmo_hit) state_d = NAK;
`endif
      ISSUE: begin
        cmd_new_d = 1'b1;
        state_d = out_cnt_q == '0 ? S_END : S_RSP;
      end
      WAIT: if (i_resp_ready) begin
        resp_d = i_resp_data;
        state_d = TX;
      end else if (tmo_hit) state_d = NAK;
      TX: begin
        send = 1'b1;
        send_byte = tx_byte;
        send_ret = out_cnt_q == CW'(1) ? S_END : TX;
        out_cnt_d = out_cnt_q - 1'b1;
      end
      TXW: if (done_edge) state_d = ret_q;
      NAK: send = 1'b1;
      default: state_d = IDLE;
    endcase
    if (send) begin
      tx_start_d = 1'b1;
      tx_data_d = send_byte;
      ret_d = send_ret;
      state_d = TXW;
    end
    own_d = state_d == IDLE ? 1'b0 : state_q == ISSUE ? 1'b1 : own_q;
    // idle timer restarts on every state entry and every received byte
    tmo_d = (state_d != state_q || rx_edge) ? '0 : (state_q == RX || state_q == WAIT) ? tmo_q + 1'b1 : tmo_q;
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      cmd_q <= '0;
      data_q <= '0;
      resp_q <= '0;
      tmo_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
      cmd_new_q <= 1'b0;
      own_q <= 1'b0;
      rx_new_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      cmd_q <= cmd_d;
      data_q <= data_d;
      resp_q <= resp_d;
      tmo_q <= tmo_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
      cmd_new_q <= cmd_new_d;
      own_q <= own_d;
      rx_new_q <= rx_new_d;
      tx_done_q <= tx_done_d;
    end
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_cmd      = cmd_q;
  assign o_cmd_data = data_q;
  assign o_cmd_new  = cmd_new_q;
  assign o_loopback = !(own_q || state_q == ISSUE || state_q == TXW);
endmodule

// File: tb/tb_cmd_engine.sv
// tb_cmd_engine: table-driven command vectors with a TX/strobe scoreboard, plus latency, timeout, error and reset sequences.
module tb_cmd_engine;
  localparam int PB = 4;
  localparam int TMO = 100;
`ifdef CMD_ENGINE_CLI_EN
  localparam int GAP = 15;
`else
  localparam int GAP = 0;
`endif
  logic clk = 1'b0;
  logic i_rst = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic i_rx_new = 1'b0, i_rx_err = 1'b0, i_tx_done = 1'b0, i_resp_ready = 1'b0;
  logic [8*PB-1:0] i_resp_data = '0;
  logic o_tx_start, o_cmd_new, o_loopback;
  logic [7:0] o_tx_data, o_cmd;
  logic [8*PB-1:0] o_cmd_data;
  int checks = 0, errors = 0, n_strobe = 0, n_start = 0, epoch = 0;
  logic [39:0] cmd_exp[$];
  logic [7:0] tx_exp[$];
  typedef struct {
    logic [7:0] op;
    logic [63:0] pay;
    int npay;
    logic [31:0] resp;
    bit strobe;
    logic [31:0] exp_data;
    int ntx;
    logic [63:0] exp_tx;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  cmd_engine #(.P_DATA_BYTES(PB), .P_TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_new(i_rx_new), .i_rx_err(i_rx_err),
    .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_cmd(o_cmd),
    .o_cmd_data(o_cmd_data), .o_cmd_new(o_cmd_new), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .o_loopback(o_loopback)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // command strobe scoreboard
  always @(negedge clk)
    if (i_rst && o_cmd_new) begin
      logic [39:0] e;
      n_strobe++;
      e = cmd_exp.size() != 0 ? cmd_exp.pop_front() : 40'hFF_FFFF_FFFF;
      check("cmd_new_op", {32'h0, o_cmd}, {32'h0, e[39:32]});
      check("cmd_new_data", {32'h0, o_cmd_data}, {32'h0, e[31:0]});
    end

  // UART TX model: acknowledges each byte a few cycles after its start pulse
  initial begin
    logic [7:0] b;
    logic [63:0] e;
    int ep;
    forever begin
      @(negedge clk);
      if (i_rst && o_tx_start) begin
        n_start++;
        b = o_tx_data;
        ep = epoch;
        e = tx_exp.size() != 0 ? {56'h0, tx_exp.pop_front()} : 64'h100;
        check("tx_byte", {56'h0, b}, e);
        check("tx_loopback_low", {63'h0, o_loopback}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        if (ep == epoch) check("tx_data_hold", {56'h0, o_tx_data}, {56'h0, b});
        i_tx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 i_rx_data = b;
    i_rx_new = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rx_new = 1'b0;
    @(posedge clk);
  endtask

  task automatic raise_byte(input logic [7:0] b);
    @(posedge clk);
    #1 i_rx_data = b;
    i_rx_new = 1'b1;
  endtask

  // posedges from now until the selected output is seen (-1 when the bound expires)
  task automatic wait_for(input int which, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if ((which == 0 && o_cmd_new) || (which == 1 && o_tx_start)) return;
    end
    n = -1;
  endtask

  task automatic run_vec(input vec_t v);
    int s0, t0;
    s0 = n_strobe;
    t0 = n_start;
    i_resp_data = v.resp;
    i_resp_ready = 1'b1;
    if (v.strobe) cmd_exp.push_back({v.op, v.exp_data});
    for (int k = v.ntx - 1; k >= 0; k--) tx_exp.push_back(v.exp_tx[8*k +: 8]);
    send_byte(v.op);
    repeat (GAP) @(posedge clk);
    for (int k = v.npay - 1; k >= 0; k--) send_byte(v.pay[8*k +: 8]);
    repeat (100) @(posedge clk);
    check("vec_strobes", 64'(n_strobe - s0), {63'h0, v.strobe});
    check("vec_tx_count", 64'(n_start - t0), 64'(v.ntx));
    check("vec_loopback_idle", {63'h0, o_loopback}, 64'h1);
  endtask

  initial begin
    int n, s0, t0;
`ifdef CMD_ENGINE_CLI_EN
    vt.push_back('{8'h70, 64'h3461, 2, 32'h5C, 1, 32'h4A, 6, 64'h3A3E35430D0A});
    vt.push_back('{8'h77, 64'h4445414462656566, 8, 32'h0, 1, 32'hDEADBEEF, 3, 64'h3A0D0A});
    vt.push_back('{8'h41, 64'h0, 0, 32'h0, 0, 32'h0, 3, 64'h150D0A});
    vt.push_back('{8'h77, 64'h3147, 2, 32'h0, 0, 32'h0, 4, 64'h3A150D0A});
    vt.push_back('{8'h70, 64'h4630, 2, 32'hA7, 1, 32'hF0, 6, 64'h3A3E41370D0A});
`else
    vt.push_back('{8'h77, 64'hDEADBEEF, 4, 32'h0, 1, 32'hDEADBEEF, 0, 64'h0});
    vt.push_back('{8'h72, 64'h0, 0, 32'h01020304, 1, 32'h0, 4, 64'h01020304});
    vt.push_back('{8'h70, 64'h4A, 1, 32'h5C, 1, 32'h4A, 1, 64'h5C});
    vt.push_back('{8'h41, 64'h0, 0, 32'h0, 0, 32'h0, 1, 64'h15});
    vt.push_back('{8'h72, 64'h0, 0, 32'hA5B6C7D8, 1, 32'h0, 4, 64'hA5B6C7D8});
    vt.push_back('{8'h77, 64'h00000001, 4, 32'h0, 1, 32'h00000001, 0, 64'h0});
    vt.push_back('{8'h70, 64'hFF, 1, 32'h123456FF, 1, 32'hFF, 1, 64'hFF});
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", {63'h0, o_tx_start}, 64'h0);
    check("rst_tx_data", {56'h0, o_tx_data}, 64'h0);
    check("rst_cmd", {56'h0, o_cmd}, 64'h0);
    check("rst_cmd_data", {32'h0, o_cmd_data}, 64'h0);
    check("rst_cmd_new", {63'h0, o_cmd_new}, 64'h0);
    check("rst_loopback", {63'h0, o_loopback}, 64'h1);
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);
`ifndef CMD_ENGINE_CLI_EN
    // read: opcode edge -> strobe 3 posedges later; ready -> tx_start 2 posedges later
    cmd_exp.push_back({8'h72, 32'h0});
    tx_exp.push_back(8'h11); tx_exp.push_back(8'h22); tx_exp.push_back(8'h33); tx_exp.push_back(8'h44);
    i_resp_ready = 1'b0;
    i_resp_data = 32'h11223344;
    raise_byte(8'h72);
    wait_for(0, n);
    check("lat_cmd_new_read", 64'(n), 64'd3);
    check("read_loopback_wait", {63'h0, o_loopback}, 64'h0);
    i_resp_ready = 1'b1;
    wait_for(1, n);
    check("lat_resp_to_tx", 64'(n), 64'd2);
    i_rx_new = 1'b0;
    repeat (60) @(posedge clk);
    check("read_loopback_after", {63'h0, o_loopback}, 64'h1);
    // write: last payload byte edge -> strobe 2 posedges later
    cmd_exp.push_back({8'h77, 32'hCAFEF00D});
    send_byte(8'h77); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0);
    raise_byte(8'h0D);
    wait_for(0, n);
    check("lat_cmd_new_write", 64'(n), 64'd2);
    i_rx_new = 1'b0;
    repeat (10) @(posedge clk);
    // inter-byte timeout: NAK, no strobe
    s0 = n_strobe;
    tx_exp.push_back(8'h15);
    send_byte(8'h77);
    raise_byte(8'h55);
    wait_for(1, n);
    check("tmo_rx_latency", 64'(n), 64'd102);
    i_rx_new = 1'b0;
    repeat (20) @(posedge clk);
    check("tmo_rx_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("tmo_rx_partial", {32'h0, o_cmd_data}, 64'h55);
    // response timeout: strobe then NAK
    i_resp_ready = 1'b0;
    cmd_exp.push_back({8'h72, 32'h0});
    tx_exp.push_back(8'h15);
    raise_byte(8'h72);
    wait_for(1, n);
    check("tmo_wait_latency", 64'(n), 64'd104);
    i_rx_new = 1'b0;
    repeat (20) @(posedge clk);
    check("tmo_wait_pending", 64'(tx_exp.size() + cmd_exp.size()), 64'd0);
    // framing error mid-payload
    s0 = n_strobe;
    t0 = n_start;
    tx_exp.push_back(8'h15);
    send_byte(8'h77);
    send_byte(8'h12);
    @(posedge clk);
    #1 i_rx_err = 1'b1;
    repeat (30) @(posedge clk);
    #1 i_rx_err = 1'b0;
    check("rxerr_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("rxerr_nak_count", 64'(n_start - t0), 64'd1);
    check("rxerr_partial", {32'h0, o_cmd_data}, 64'h12);
    // reset in the middle of a read response
    i_resp_ready = 1'b1;
    i_resp_data = 32'h0A0B0C0D;
    cmd_exp.push_back({8'h72, 32'h0});
    tx_exp.push_back(8'h0A);
    raise_byte(8'h72);
    wait_for(1, n);
    check("rst_mid_first_tx", 64'(n), 64'd5);
    i_rx_new = 1'b0;
    @(posedge clk);
    #1 i_rst = 1'b0;
    epoch++;
    #1;
    check("rstmid_tx_start", {63'h0, o_tx_start}, 64'h0);
    check("rstmid_tx_data", {56'h0, o_tx_data}, 64'h0);
    check("rstmid_cmd", {56'h0, o_cmd}, 64'h0);
    check("rstmid_cmd_data", {32'h0, o_cmd_data}, 64'h0);
    check("rstmid_cmd_new", {63'h0, o_cmd_new}, 64'h0);
    check("rstmid_loopback", {63'h0, o_loopback}, 64'h1);
    tx_exp.delete();
    cmd_exp.delete();
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b1;
    t0 = n_start;
    repeat (40) @(posedge clk);
    check("rstmid_no_more_tx", 64'(n_start - t0), 64'd0);
`endif
    repeat (10) @(posedge clk);
    check("end_pending", 64'(tx_exp.size() + cmd_exp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/cmd_engine.md
# cmd_engine

Parametrised UART command engine: the next generation of the command controller, between the UART RX/TX pair and the register/command back end. Parses single-byte opcodes with a configurable payload width and issues a one-cycle command strobe. Serialises the back-end response, with inter-byte and response timeouts and NAK reporting. Optional ASCII-hex CLI framing for terminal use.

## Interface
- P_DATA_BYTES, 8: payload/response width in bytes (1..8); data buses are 8*P_DATA_BYTES bits.
- P_TIMEOUT_CYC, 1000000: idle cycles tolerated between RX bytes, or while awaiting a response (>=2).
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_rx_data  in  8  received byte, valid on i_rx_new rising edge.
- i_rx_new  in  1  level from UART RX; rising edge marks a new byte.
- i_rx_err  in  1  RX framing error, level.
- i_tx_done  in  1  level from UART TX; rising edge marks byte sent.
- o_tx_start  out  1  one-cycle TX start pulse.
- o_tx_data  out  8  TX byte; held from o_tx_start until done edge.
- o_cmd  out  8  current opcode.
- o_cmd_data  out  8*P_DATA_BYTES  command payload, MSB byte first as received.
- o_cmd_new  out  1  one-cycle command strobe.
- i_resp_ready  in  1  level; response valid.
- i_resp_data  in  8*P_DATA_BYTES  response, sampled on first cycle i_resp_ready high in WAIT.
- o_loopback  out  1  1 = UART echo permitted; 0 while engine owns TX.

## Operation
- Opcodes: 'p' 0x70 ping (in 1 byte, out 1 byte), 'r' 0x72 read (in 0, out P_DATA_BYTES), 'w' 0x77 write (in P_DATA_BYTES, out 0). Any other opcode -> NAK 0x15 sent, no o_cmd_new.
- States: IDLE, DECODE, PRE_D, RX, ISSUE, PRE_R, WAIT, TX, TXW, CR, LF, NAK.
- IDLE: on rx rising edge latch o_cmd, clear payload shift register -> DECODE. i_rx_err ignored.
- DECODE: load in/out byte counters; unknown -> NAK; CLI -> PRE_D; else in count 0 -> ISSUE, else RX.
- RX: each byte shifts in: payload = (payload << 8) | byte; count 0 -> ISSUE.
- ISSUE: pulse o_cmd_new; out count 0 -> IDLE (binary) / CR (CLI); else PRE_R (CLI) / WAIT.
- WAIT: on i_resp_ready capture i_resp_data -> TX.
- TX: send response MSB byte first, through TXW; decrement count; at 0 -> IDLE (binary) / CR (CLI).
- TXW: o_tx_start low; on tx_done rising edge return to caller state.
- Timeout: counter reset on every state entry and every RX byte; counts in RX and WAIT; reaching P_TIMEOUT_CYC -> NAK.
- i_rx_err high in RX -> NAK. o_cmd_data keeps partial value; o_cmd_new not pulsed.
- NAK: send 0x15 via TXW -> IDLE.
- o_loopback: 0 from ISSUE until return to IDLE, and during any TXW; 1 otherwise.
- o_cmd, o_cmd_data stable from o_cmd_new until next opcode accepted.

## Timing
- Reset: o_tx_start 0, o_tx_data 0x00, o_cmd 0x00, o_cmd_data 0, o_cmd_new 0, o_loopback 1; state IDLE; counters 0. Reset mid-operation aborts immediately, no pending strobe/TX.
- Edge detectors registered; a byte edge at cycle N is acted on in cycle N (detector uses previous-cycle level).
- Binary read: opcode edge N -> DECODE N+1 -> ISSUE N+2 -> o_cmd_new high N+3 only.
- Last payload byte edge at M -> o_cmd_new high M+2.
- i_resp_ready high at cycle K in WAIT -> o_tx_start high K+2.
- An RX edge coinciding with a TX done edge: both honoured; RX bytes arriving outside IDLE/RX are dropped.
- Back-to-back commands: new opcode accepted first cycle back in IDLE.

## Configuration
- CMD_ENGINE_CLI_EN defined: CLI framing. ':' 0x3A sent before payload entry; payload entered as 2*P_DATA_BYTES ASCII hex chars ('0'-'9','a'-'f','A'-'F', nibble-shifted); non-hex char -> NAK. '>' 0x3E sent before response; response sent as uppercase hex, MSB nibble first; then CR 0x0D, LF 0x0A. NAK also followed by CR LF.
- Undefined: binary only; PRE_D, PRE_R, CR, LF states and hex logic absent.

## Test plan
- Binary write, P_DATA_BYTES=4: 0x77,DE,AD,BE,EF -> o_cmd_new one cycle, o_cmd=0x77, o_cmd_data=0xDEADBEEF, no TX.
- Binary read: 0x72, i_resp_data=0x01020304 -> TX 01,02,03,04 in order, o_loopback 0 throughout, 1 after.
- CLI ping: 'p',"4","a", resp 0x5C -> TX ':', '>', '5','C',0x0D,0x0A; o_cmd_data=0x4A.
- Unknown opcode 0x41 -> TX 0x15 only, o_cmd_new never high; next 'r' processed normally.
- Timeout, P_TIMEOUT_CYC=100: 'w' then one byte, silence -> NAK after 100 cycles, no o_cmd_new; same for i_resp_ready never asserted.
- i_rst low mid-TX of read response -> all outputs at reset values next cycle; no further o_tx_start.
